// File: rtl/router_ctrl_rr_if.sv
// Handshake and flit bundle between the ring-router controller (master) and its FIFOs/arbiter (slave).
interface router_ctrl_rr_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
);
  logic              start_req;
  logic [ADDR_W-1:0] src_addr;
  logic              done;
  logic              read_req;
  logic              read_gnt;
  logic [ADDR_W-1:0] arb_src_addr;
  logic              write_req;
  logic              write_gnt;
  logic [ADDR_W-1:0] arb_dst_addr;
  logic              valid_dfx_data;
  logic [ADDR_W-1:0] dst_addr_recv;
  logic              out0_rd;
  logic              local_empty;
  logic [DATA_W-1:0] local_data;
  logic              local_rd;
  logic              ring_empty;
  logic [DATA_W-1:0] ring_data;
  logic              ring_rd;
  logic              local_out_full;
  logic              ring_out_full;
  logic [DATA_W-1:0] local_out_data;
  logic              local_out_we;
  logic [DATA_W-1:0] ring_out_data;
  logic              ring_out_we;

  modport master (
    input  start_req, src_addr, read_gnt, write_gnt, valid_dfx_data, dst_addr_recv,
           local_empty, local_data, ring_empty, ring_data, local_out_full, ring_out_full,
    output done, read_req, arb_src_addr, write_req, arb_dst_addr, out0_rd,
           local_rd, ring_rd, local_out_data, local_out_we, ring_out_data, ring_out_we
  );

  modport slave (
    output start_req, src_addr, read_gnt, write_gnt, valid_dfx_data, dst_addr_recv,
           local_empty, local_data, ring_empty, ring_data, local_out_full, ring_out_full,
    input  done, read_req, arb_src_addr, write_req, arb_dst_addr, out0_rd,
           local_rd, ring_rd, local_out_data, local_out_we, ring_out_data, ring_out_we
  );
endinterface

// File: rtl/router_ctrl_rr.sv
// Ring-router controller: header stamping, TTL forwarding/drop, round-robin local/ring
// arbitration into registered egress, plus read/write memory-arbiter handshake FSMs.
module router_ctrl_rr #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 10,
  parameter int SRC_W         = 2,
  parameter int NUM_W         = 5,
  parameter int TTL_W         = 2,
  parameter int NUMBER_PACKET = 19,
  parameter int TTL_INIT      = 2,
  parameter int MY_ID         = 0,
  parameter int READ_BEATS    = 5
) (
  input logic            clk,
  input logic            rst,
  router_ctrl_rr_if.master bus
);
  localparam int HDR_W   = SRC_W + NUM_W + TTL_W;
  localparam int TTL_LSB = SRC_W + NUM_W;
  localparam int CNT_W   = $clog2(READ_BEATS + 1);

  localparam logic [SRC_W-1:0] MY_SRC    = SRC_W'(MY_ID);
  localparam logic [TTL_W-1:0] TTL_STAMP = TTL_W'(TTL_INIT);
  localparam logic [NUM_W-1:0] PKT_LAST  = NUM_W'(NUMBER_PACKET);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(READ_BEATS - 1);

  typedef enum logic       {RR_LOCAL, RR_RING}          rr_e;
  typedef enum logic       {RD_IDLE, RD_REQ}            rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_POP}    wr_state_e;

  rr_e              rr_ptr;
  rd_state_e        rd_state;
  wr_state_e        wr_state;
  logic [NUM_W-1:0] pkt_num;
  logic [CNT_W-1:0] rd_cnt;

  logic [TTL_W-1:0]  ring_ttl;
  logic [SRC_W-1:0]  ring_src;
  logic              ring_drop, ring_sink, ring_bcast;
  logic              ring_elig, local_elig, contested;
  logic              grant_local, grant_ring;
  logic [DATA_W-1:0] ring_fwd, local_stamped;

  assign ring_ttl   = bus.ring_data[TTL_LSB +: TTL_W];
  assign ring_src   = bus.ring_data[SRC_W-1:0];
  assign ring_drop  = (ring_src == MY_SRC) || (ring_ttl == '0);
  assign ring_sink  = !ring_drop && (ring_ttl == TTL_W'(1));
  assign ring_bcast = !ring_drop && !ring_sink;

  // Eligibility is gated by rst so no FIFO is popped while the controller is held in reset.
  assign ring_elig  = !rst && !bus.ring_empty &&
                      (ring_drop || (ring_sink && !bus.local_out_full) ||
                       (ring_bcast && !bus.local_out_full && !bus.ring_out_full));
  assign local_elig = !rst && !bus.local_empty && !bus.ring_out_full;
  assign contested  = local_elig && ring_elig;

  assign grant_local  = local_elig && (!ring_elig || rr_ptr == RR_LOCAL);
  assign grant_ring   = ring_elig && !grant_local;
  assign bus.local_rd = grant_local;
  assign bus.ring_rd  = grant_ring;

  // NOTE: every always_comb target gets a full default first so no latch can be inferred.
  always_comb begin
    ring_fwd                       = bus.ring_data;
    ring_fwd[TTL_LSB +: TTL_W]     = ring_ttl - TTL_W'(1);
    local_stamped                  = bus.local_data;
    local_stamped[HDR_W-1:0]       = {TTL_STAMP, pkt_num, MY_SRC};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too because they are visible outputs that must read 0.
      rr_ptr             <= RR_LOCAL;
      pkt_num            <= NUM_W'(1);
      bus.local_out_we   <= 1'b0;
      bus.ring_out_we    <= 1'b0;
      bus.local_out_data <= '0;
      bus.ring_out_data  <= '0;
    end else begin
      bus.local_out_we <= grant_ring && !ring_drop;
      bus.ring_out_we  <= grant_local || (grant_ring && ring_bcast);
      if (grant_ring && !ring_drop) bus.local_out_data <= ring_fwd;
      if (grant_local) begin
        bus.ring_out_data <= local_stamped;
        pkt_num           <= (pkt_num == PKT_LAST) ? NUM_W'(1) : pkt_num + NUM_W'(1);
      end else if (grant_ring && ring_bcast) begin
        bus.ring_out_data <= ring_fwd;
      end
      if (contested) rr_ptr <= (rr_ptr == RR_LOCAL) ? RR_RING : RR_LOCAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state         <= RD_IDLE;
      rd_cnt           <= '0;
      bus.read_req     <= 1'b0;
      bus.done         <= 1'b0;
      bus.arb_src_addr <= {ADDR_W{1'b0}};
    end else begin
      bus.done <= 1'b0;
      case (rd_state)
        RD_IDLE: if (bus.start_req) begin
          rd_state         <= RD_REQ;
          rd_cnt           <= '0;
          bus.read_req     <= 1'b1;
          bus.arb_src_addr <= bus.src_addr;
        end
        RD_REQ: begin
          // Dropping start_req abandons the burst even on a granted cycle.
          if (!bus.start_req) begin
            rd_state     <= RD_IDLE;
            rd_cnt       <= '0;
            bus.read_req <= 1'b0;
          end else if (bus.read_gnt) begin
            if (rd_cnt == BEAT_LAST) begin
              rd_state     <= RD_IDLE;
              rd_cnt       <= '0;
              bus.read_req <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + CNT_W'(1);
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state         <= WR_IDLE;
      bus.write_req    <= 1'b0;
      bus.out0_rd      <= 1'b0;
      bus.arb_dst_addr <= {ADDR_W{1'b0}};
    end else begin
      bus.out0_rd <= 1'b0;
      case (wr_state)
        WR_IDLE: if (bus.valid_dfx_data) begin
          wr_state         <= WR_REQ;
          bus.write_req    <= 1'b1;
          bus.arb_dst_addr <= bus.dst_addr_recv;
        end
        WR_REQ: begin
          if (!bus.valid_dfx_data) begin
            wr_state      <= WR_IDLE;
            bus.write_req <= 1'b0;
          end else if (bus.write_gnt) begin
            wr_state      <= WR_POP;
            bus.write_req <= 1'b0;
            bus.out0_rd   <= 1'b1;
          end
        end
        // One settling cycle so the popped flit's stale valid is not re-requested.
        WR_POP:  wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_ctrl_rr.sv
// Self-checking bench for router_ctrl_rr: vector table, hand sequences for FSMs/reset,
// and a randomized run against an arithmetic reference model of the forwarding rules.
module tb_router_ctrl_rr;
  localparam int DATA_W        = 64;
  localparam int ADDR_W        = 10;
  localparam int MY_ID         = 1;
  localparam int NUMBER_PACKET = 19;
  localparam int NUM_LSB       = 2;
  localparam int TTL_LSB       = 7;
  localparam int HDR_W         = 9;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  router_ctrl_rr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  router_ctrl_rr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MY_ID(MY_ID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        le, re, lf, rf;
    logic [63:0] ld, rd;
    logic        lrd, rrd, lwe, rwe;
    logic [63:0] ldat, rdat;
  } vec_t;

  function automatic logic [63:0] mk(input logic [54:0] upper, input int ttl, input int num,
                                     input int src);
    return {upper, ttl[1:0], num[4:0], src[1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_req      = 1'b0;
    bus.src_addr       = '0;
    bus.read_gnt       = 1'b0;
    bus.write_gnt      = 1'b0;
    bus.valid_dfx_data = 1'b0;
    bus.dst_addr_recv  = '0;
    bus.local_empty    = 1'b1;
    bus.local_data     = '0;
    bus.ring_empty     = 1'b1;
    bus.ring_data      = '0;
    bus.local_out_full = 1'b0;
    bus.ring_out_full  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_read_req"},  bus.read_req, 0);
    check({tag, "_arb_src"},   bus.arb_src_addr, 0);
    check({tag, "_write_req"}, bus.write_req, 0);
    check({tag, "_arb_dst"},   bus.arb_dst_addr, 0);
    check({tag, "_out0_rd"},   bus.out0_rd, 0);
    check({tag, "_local_rd"},  bus.local_rd, 0);
    check({tag, "_ring_rd"},   bus.ring_rd, 0);
    check({tag, "_lo_data"},   bus.local_out_data, 0);
    check({tag, "_lo_we"},     bus.local_out_we, 0);
    check({tag, "_ro_data"},   bus.ring_out_data, 0);
    check({tag, "_ro_we"},     bus.ring_out_we, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  vec_t        tbl [11];
  logic [63:0] ld_hold;
  // Reference model state
  logic [63:0] m_ldat, m_rdat;
  int          m_injected;
  bit          m_ring_turn;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // ---------------- vector table ----------------
    tbl[0]  = '{1, 0, 0, 0, 64'd0, mk(55'h1A2B3C4D5E6F7, 3, 5, 2),
                0, 1, 1, 1, mk(55'h1A2B3C4D5E6F7, 2, 5, 2), mk(55'h1A2B3C4D5E6F7, 2, 5, 2)};
    tbl[1]  = '{1, 0, 0, 0, 64'd0, mk(55'h0000000000B0B, 1, 6, 3),
                0, 1, 1, 0, mk(55'h0000000000B0B, 0, 6, 3), 64'd0};
    tbl[2]  = '{1, 0, 0, 0, 64'd0, mk(55'h0000000000C0C, 0, 7, 0),
                0, 1, 0, 0, 64'd0, 64'd0};
    tbl[3]  = '{1, 0, 0, 0, 64'd0, mk(55'h0000000000D0D, 2, 8, 1),
                0, 1, 0, 0, 64'd0, 64'd0};
    tbl[4]  = '{0, 1, 0, 0, mk(55'h0000000000E0E, 3, 31, 3), 64'd0,
                1, 0, 0, 1, 64'd0, mk(55'h0000000000E0E, 2, 1, 1)};
    tbl[5]  = '{0, 0, 0, 1, mk(55'h0000000000F0F, 0, 0, 0), mk(55'h0000000001111, 2, 9, 2),
                0, 0, 0, 0, 64'd0, 64'd0};
    tbl[6]  = '{0, 0, 0, 1, mk(55'h0000000000F0F, 0, 0, 0), mk(55'h0000000002222, 1, 10, 0),
                0, 1, 1, 0, mk(55'h0000000002222, 0, 10, 0), 64'd0};
    tbl[7]  = '{0, 0, 0, 1, mk(55'h0000000000F0F, 0, 0, 0), mk(55'h0000000003333, 3, 11, 1),
                0, 1, 0, 0, 64'd0, 64'd0};
    tbl[8]  = '{0, 0, 1, 0, mk(55'h0000000004444, 0, 0, 0), mk(55'h0000000005555, 1, 12, 2),
                1, 0, 0, 1, 64'd0, mk(55'h0000000004444, 2, 2, 1)};
    tbl[9]  = '{0, 0, 0, 0, mk(55'h0000000006666, 1, 1, 1), mk(55'h0000000007777, 2, 13, 3),
                1, 0, 0, 1, 64'd0, mk(55'h0000000006666, 2, 3, 1)};
    tbl[10] = '{0, 0, 0, 0, mk(55'h0000000008888, 1, 1, 1), mk(55'h0000000009999, 2, 14, 0),
                0, 1, 1, 1, mk(55'h0000000009999, 1, 14, 0), mk(55'h0000000009999, 1, 14, 0)};

    for (int i = 0; i < 11; i++) begin
      bus.local_empty    = tbl[i].le;
      bus.ring_empty     = tbl[i].re;
      bus.local_out_full = tbl[i].lf;
      bus.ring_out_full  = tbl[i].rf;
      bus.local_data     = tbl[i].ld;
      bus.ring_data      = tbl[i].rd;
      #1;
      check($sformatf("vec%0d_local_rd", i), bus.local_rd, tbl[i].lrd);
      check($sformatf("vec%0d_ring_rd", i),  bus.ring_rd,  tbl[i].rrd);
      tick();
      check($sformatf("vec%0d_lo_we", i), bus.local_out_we, tbl[i].lwe);
      check($sformatf("vec%0d_ro_we", i), bus.ring_out_we,  tbl[i].rwe);
      if (tbl[i].lwe) check($sformatf("vec%0d_lo_data", i), bus.local_out_data, tbl[i].ldat);
      if (tbl[i].rwe) check($sformatf("vec%0d_ro_data", i), bus.ring_out_data,  tbl[i].rdat);
    end

    // ---------------- local-only stream, packet-number wrap ----------------
    do_reset();
    for (int i = 0; i < 21; i++) begin
      ld_hold          = {$urandom(), $urandom()};
      bus.local_empty  = 1'b0;
      bus.local_data   = ld_hold;
      #1;
      check("stream_local_rd", bus.local_rd, 1);
      tick();
      check("stream_ro_we", bus.ring_out_we, 1);
      check("stream_pkt", (bus.ring_out_data >> NUM_LSB) % 32, (i % NUMBER_PACKET) + 1);
      check("stream_ttl", (bus.ring_out_data >> TTL_LSB) % 4, 2);
      check("stream_src", bus.ring_out_data % 4, MY_ID);
      check("stream_upper", bus.ring_out_data >> HDR_W, ld_hold >> HDR_W);
    end
    bus.local_empty = 1'b1;
    tick();
    check("stream_end_ro_we", bus.ring_out_we, 0);

    // ---------------- round-robin alternation ----------------
    do_reset();
    bus.local_empty = 1'b0;
    bus.ring_empty  = 1'b0;
    bus.local_data  = mk(55'h00000000000AA, 0, 0, 0);
    bus.ring_data   = mk(55'h00000000000BB, 2, 4, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("alt%0d_local_rd", i), bus.local_rd, (i % 2) == 0);
      check($sformatf("alt%0d_ring_rd", i),  bus.ring_rd,  (i % 2) == 1);
      tick();
    end
    idle_inputs();
    tick();

    // ---------------- read burst with gaps, back-to-back restart ----------------
    bus.start_req = 1'b1;
    bus.src_addr  = 10'h2A5;
    for (int c = 0; c < 9; c++) begin
      bus.read_gnt = (c == 2 || c == 3 || c == 5 || c == 6 || c == 7);
      tick();
      if (c == 0) bus.src_addr = 10'h0F0;
      check($sformatf("rd_req_c%0d", c + 1), bus.read_req, (c + 1) != 8);
      check($sformatf("rd_done_c%0d", c + 1), bus.done, (c + 1) == 8);
      if (c < 8) check($sformatf("rd_addr_c%0d", c + 1), bus.arb_src_addr, 10'h2A5);
    end
    check("rd_restart_addr", bus.arb_src_addr, 10'h0F0);
    bus.start_req = 1'b0;
    bus.read_gnt  = 1'b0;
    tick();
    check("rd_stop_req", bus.read_req, 0);
    check("rd_stop_done", bus.done, 0);

    // ---------------- read abort after 3 grants, then a clean burst ----------------
    for (int c = 0; c < 8; c++) begin
      bus.start_req = (c < 5);
      bus.read_gnt  = (c >= 2 && c <= 4);
      tick();
      check($sformatf("abort_req_c%0d", c + 1), bus.read_req, (c + 1) <= 5);
      check($sformatf("abort_done_c%0d", c + 1), bus.done, 0);
    end
    for (int c = 0; c < 7; c++) begin
      bus.start_req = (c < 6);
      bus.read_gnt  = (c >= 1 && c <= 5);
      tick();
      check($sformatf("reburst_req_c%0d", c + 1), bus.read_req, (c + 1) <= 5);
      check($sformatf("reburst_done_c%0d", c + 1), bus.done, (c + 1) == 6);
    end
    idle_inputs();

    // ---------------- write handshake ----------------
    bus.valid_dfx_data = 1'b1;
    bus.dst_addr_recv  = 10'h155;
    for (int c = 0; c < 7; c++) begin
      bus.write_gnt      = (c == 3);
      bus.valid_dfx_data = (c < 4);
      if (c == 1) bus.dst_addr_recv = 10'h0AA;
      tick();
      check($sformatf("wr_req_c%0d", c + 1), bus.write_req, (c + 1) >= 1 && (c + 1) <= 3);
      check($sformatf("wr_pop_c%0d", c + 1), bus.out0_rd, (c + 1) == 4);
      check($sformatf("wr_addr_c%0d", c + 1), bus.arb_dst_addr, 10'h155);
    end

    // ---------------- write abort ----------------
    bus.dst_addr_recv = 10'h2CC;
    for (int c = 0; c < 4; c++) begin
      bus.valid_dfx_data = (c == 0);
      tick();
      check($sformatf("wab_req_c%0d", c + 1), bus.write_req, (c + 1) == 1);
      check($sformatf("wab_pop_c%0d", c + 1), bus.out0_rd, 0);
      check($sformatf("wab_addr_c%0d", c + 1), bus.arb_dst_addr, 10'h2CC);
    end
    idle_inputs();

    // ---------------- reset mid-operation ----------------
    do_reset();
    bus.start_req      = 1'b1;
    bus.src_addr       = 10'h3FF;
    bus.valid_dfx_data = 1'b1;
    bus.dst_addr_recv  = 10'h1EE;
    bus.local_empty    = 1'b0;
    bus.local_data     = mk(55'h0000000012345, 0, 0, 0);
    tick();
    tick();
    tick();
    check("midop_pre_read_req", bus.read_req, 1);
    check("midop_pre_ro_we", bus.ring_out_we, 1);
    rst = 1'b1;
    tick();
    check_all_zero("midop");
    idle_inputs();
    rst = 1'b0;
    bus.local_empty = 1'b0;
    bus.local_data  = mk(55'h0000000054321, 0, 0, 0);
    #1;
    check("post_rst_local_rd", bus.local_rd, 1);
    tick();
    check("post_rst_pkt", bus.ring_out_data, mk(55'h0000000054321, 2, 1, 1));
    idle_inputs();

    // ---------------- randomized forwarding vs. reference model ----------------
    do_reset();
    m_ldat      = '0;
    m_rdat      = '0;
    m_injected  = 0;
    m_ring_turn = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic [63:0] ld, rd, stamp, fwd;
      int          ttl, src;
      bit          le, re, lf, rf, drop, l_ok, r_ok, win_l, win_r;
      le = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 3) == 0);
      lf = ($urandom_range(0, 4) == 0);
      rf = ($urandom_range(0, 4) == 0);
      ld = {$urandom(), $urandom()};
      rd = {$urandom(), $urandom()};
      bus.local_empty    = le;
      bus.ring_empty     = re;
      bus.local_out_full = lf;
      bus.ring_out_full  = rf;
      bus.local_data     = ld;
      bus.ring_data      = rd;

      ttl  = int'((rd >> TTL_LSB) % 4);
      src  = int'(rd % 4);
      drop = (src == MY_ID) || (ttl == 0);
      r_ok = !re && (drop || (ttl == 1 && !lf) || (ttl > 1 && !lf && !rf));
      l_ok = !le && !rf;
      win_l = l_ok && (!r_ok || !m_ring_turn);
      win_r = r_ok && (!l_ok || m_ring_turn);
      if (l_ok && r_ok) m_ring_turn = !m_ring_turn;

      fwd   = rd - (64'd1 << TTL_LSB);
      stamp = ((ld >> HDR_W) << HDR_W) + (64'd2 << TTL_LSB)
            + (64'((m_injected % NUMBER_PACKET) + 1) << NUM_LSB) + 64'(MY_ID);
      if (win_r && !drop) m_ldat = fwd;
      if (win_l) begin
        m_rdat = stamp;
        m_injected++;
      end else if (win_r && !drop && ttl > 1) begin
        m_rdat = fwd;
      end

      #1;
      check("rnd_local_rd", bus.local_rd, win_l);
      check("rnd_ring_rd", bus.ring_rd, win_r);
      tick();
      check("rnd_lo_we", bus.local_out_we, win_r && !drop);
      check("rnd_ro_we", bus.ring_out_we, win_l || (win_r && !drop && ttl > 1));
      check("rnd_lo_data", bus.local_out_data, m_ldat);
      check("rnd_ro_data", bus.ring_out_data, m_rdat);
      check("rnd_read_req", bus.read_req, 0);
      check("rnd_out0_rd", bus.out0_rd, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
